// File: rtl/seg595_scan.sv
// Multiplexed 8-digit 7-segment scanner producing one 16-bit word per 32-cycle
// 595 driver frame; inputs are snapshotted once per scan pass so frames never tear.
module seg595_scan #(
  parameter int unsigned HOLD_FRAMES = 16,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned DIG_ACT_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp_en,
  input  logic [7:0]  digit_en,
  input  logic        lamp_test,
  output logic [15:0] data595,
  output logic        word_load,
  output logic [2:0]  scan_idx
);

  localparam int unsigned FRAME_W = 5;
  localparam int unsigned HOLD_W  = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(31);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [7:0]         SEG_XOR    = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0]         DIG_XOR    = (DIG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [15:0]        BLANK_WORD = {SEG_XOR, DIG_XOR};
  localparam logic [15:0]        LAMP_WORD  = {~SEG_XOR, ~DIG_XOR};

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic [15:0] encode(input logic [IDX_W-1:0] i,
                                         input logic [31:0]      d,
                                         input logic [7:0]       dp);
    logic [7:0] seg;
    logic [7:0] sel;
    seg    = {dp[i], hex7(d[{i, 2'b00} +: 4])};
    sel    = 8'b1 << i;
    encode = {seg ^ SEG_XOR, sel ^ DIG_XOR};
  endfunction

  logic [FRAME_W-1:0] frame_cnt, frame_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [31:0]        sh_data, sh_data_nxt;
  logic [7:0]         sh_dp, sh_dp_nxt;
  logic [7:0]         sh_en, sh_en_nxt;
  logic [15:0]        data_nxt;
  logic               load_nxt;
  logic [IDX_W-1:0]   scan_nxt;

  logic [IDX_W-1:0]   search_idx;
  logic [IDX_W-1:0]   low_idx;
  logic               boundary;
  logic               capture;

  // Next enabled shadow digit after idx, circular; the smallest offset wins.
  always_comb begin
    search_idx = idx;
    for (int k = 8; k >= 1; k--) begin
      if (sh_en[IDX_W'(idx + IDX_W'(k))]) search_idx = IDX_W'(idx + IDX_W'(k));
    end
  end

  // Lowest enabled digit of the incoming mask, 0 when none.
  always_comb begin
    low_idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (digit_en[k]) low_idx = IDX_W'(k);
    end
  end

  always_comb begin
    frame_nxt   = FRAME_W'(frame_cnt + FRAME_W'(1));
    hold_nxt    = hold_cnt;
    idx_nxt     = idx;
    sh_data_nxt = sh_data;
    sh_dp_nxt   = sh_dp;
    sh_en_nxt   = sh_en;
    data_nxt    = data595;
    scan_nxt    = scan_idx;
    boundary    = (frame_cnt == FRAME_LAST);
    load_nxt    = boundary;
    capture     = 1'b0;

    if (boundary) begin
      scan_nxt = idx;
      if (sh_en == 8'h00) begin
        data_nxt = BLANK_WORD;
        hold_nxt = '0;
        capture  = 1'b1;
      end else begin
        data_nxt = encode(idx, sh_data, sh_dp);
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt = '0;
          // A search that does not move forward closes the pass.
          if (search_idx <= idx) capture = 1'b1;
          else                   idx_nxt = search_idx;
        end else begin
          hold_nxt = HOLD_W'(hold_cnt + HOLD_W'(1));
        end
      end

      if (capture) begin
        sh_data_nxt = disp_data;
        sh_dp_nxt   = dp_en;
        sh_en_nxt   = digit_en;
        idx_nxt     = low_idx;
      end

      if (lamp_test) data_nxt = LAMP_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      hold_cnt  <= '0;
      idx       <= '0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      data595   <= BLANK_WORD;
      word_load <= 1'b0;
      scan_idx  <= '0;
    end else begin
      frame_cnt <= frame_nxt;
      hold_cnt  <= hold_nxt;
      idx       <= idx_nxt;
      sh_data   <= sh_data_nxt;
      sh_dp     <= sh_dp_nxt;
      sh_en     <= sh_en_nxt;
      data595   <= data_nxt;
      word_load <= load_nxt;
      scan_idx  <= scan_nxt;
    end
  end

endmodule

// File: tb/tb_seg595_scan.sv
// Scoreboard bench for seg595_scan with HOLD_FRAMES=2: expected per-frame words are
// queued from hand-derived constants and popped at each driver-frame boundary.
module tb_seg595_scan;

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_data = '0;
  logic [7:0]  dp_en = '0;
  logic [7:0]  digit_en = '0;
  logic        lamp_test = 1'b0;
  logic [15:0] data595;
  logic        word_load;
  logic [2:0]  scan_idx;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seg595_scan #(.HOLD_FRAMES(2), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_data (disp_data),
    .dp_en     (dp_en),
    .digit_en  (digit_en),
    .lamp_test (lamp_test),
    .data595   (data595),
    .word_load (word_load),
    .scan_idx  (scan_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full driver frame: leaves the bench just after the next boundary edge.
  task automatic step_frame();
    repeat (32) tick();
  endtask

  task automatic do_reset(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    disp_data = d;
    dp_en     = dp;
    digit_en  = en;
    lamp_test = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] w, input logic [2:0] i);
    exp_t e;
    e.word = w;
    e.idx  = i;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic ok;
    do_reset(32'h0000_0005, 8'h00, 8'h01);
    n_checks++;
    if (data595 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_data: data595=%h expected FFFF", data595);
    end
    n_checks++;
    if (word_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_load: word_load=%b expected 0", word_load);
    end
    n_checks++;
    if (scan_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idx: scan_idx=%0d expected 0", scan_idx);
    end
    ok = 1'b1;
    repeat (31) begin
      tick();
      if (word_load !== 1'b0 || data595 !== 16'hFFFF) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_quiet: early word_load or data change, ok=%b expected 1", ok);
    end
    tick();
    n_checks++;
    if (word_load !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_load: word_load=%b expected 1 at edge 32", word_load);
    end
  endtask

  task automatic test_idle_start();
    exp_t e;
    int   f;
    do_reset(32'h0000_0005, 8'h00, 8'h01);
    push(16'hFFFF, 3'd0);
    repeat (4) push(16'h92FE, 3'd0);
    f = 0;
    while (sb.size() > 0) begin
      step_frame();
      e = sb.pop_front();
      n_checks++;
      if (data595 !== e.word || scan_idx !== e.idx || word_load !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_start f%0d: data595=%h idx=%0d load=%b expected %h idx=%0d load=1",
                 f, data595, scan_idx, word_load, e.word, e.idx);
      end
      f++;
    end
  endtask

  task automatic test_skip();
    exp_t e;
    int   f;
    do_reset(32'h0000_0301, 8'h00, 8'h05);
    push(16'hFFFF, 3'd0);
    push(16'hF9FE, 3'd0);
    push(16'hF9FE, 3'd0);
    push(16'hB0FB, 3'd2);
    push(16'hB0FB, 3'd2);
    push(16'hF9FE, 3'd0);
    push(16'hF9FE, 3'd0);
    f = 0;
    while (sb.size() > 0) begin
      step_frame();
      e = sb.pop_front();
      n_checks++;
      if (data595 !== e.word || scan_idx !== e.idx || word_load !== 1'b1) begin
        n_fail++;
        $display("FAIL skip f%0d: data595=%h idx=%0d load=%b expected %h idx=%0d load=1",
                 f, data595, scan_idx, word_load, e.word, e.idx);
      end
      f++;
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    int   f;
    do_reset(32'h0000_0301, 8'h00, 8'h05);
    push(16'hFFFF, 3'd0);
    push(16'hF9FE, 3'd0);
    push(16'hF9FE, 3'd0);
    push(16'hB0FB, 3'd2);
    push(16'hB0FB, 3'd2);
    push(16'hA4FE, 3'd0);
    push(16'hA4FE, 3'd0);
    push(16'h12FB, 3'd2);
    f = 0;
    while (sb.size() > 0) begin
      step_frame();
      e = sb.pop_front();
      n_checks++;
      if (data595 !== e.word || scan_idx !== e.idx || word_load !== 1'b1) begin
        n_fail++;
        $display("FAIL snapshot f%0d: data595=%h idx=%0d load=%b expected %h idx=%0d load=1",
                 f, data595, scan_idx, word_load, e.word, e.idx);
      end
      if (f == 1) begin
        disp_data = 32'h0000_0502;
        dp_en     = 8'h04;
      end
      f++;
    end
  endtask

  task automatic test_lamp();
    exp_t e;
    int   f;
    do_reset(32'h0000_0301, 8'h00, 8'h05);
    push(16'hFFFF, 3'd0);
    push(16'hF9FE, 3'd0);
    push(16'h0000, 3'd0);
    push(16'h0000, 3'd2);
    push(16'h0000, 3'd2);
    push(16'hF9FE, 3'd0);
    push(16'hF9FE, 3'd0);
    push(16'hB0FB, 3'd2);
    f = 0;
    while (sb.size() > 0) begin
      step_frame();
      e = sb.pop_front();
      n_checks++;
      if (data595 !== e.word || scan_idx !== e.idx || word_load !== 1'b1) begin
        n_fail++;
        $display("FAIL lamp f%0d: data595=%h idx=%0d load=%b expected %h idx=%0d load=1",
                 f, data595, scan_idx, word_load, e.word, e.idx);
      end
      if (f == 1) lamp_test = 1'b1;
      if (f == 4) lamp_test = 1'b0;
      f++;
    end
  endtask

  task automatic test_single_high_digit();
    exp_t e;
    int   f;
    do_reset(32'hF000_0000, 8'h80, 8'h80);
    push(16'hFFFF, 3'd0);
    push(16'h0E7F, 3'd7);
    push(16'h0E7F, 3'd7);
    push(16'hFFFF, 3'd0);
    push(16'hFFFF, 3'd0);
    f = 0;
    while (sb.size() > 0) begin
      step_frame();
      e = sb.pop_front();
      n_checks++;
      if (data595 !== e.word || scan_idx !== e.idx || word_load !== 1'b1) begin
        n_fail++;
        $display("FAIL digit7 f%0d: data595=%h idx=%0d load=%b expected %h idx=%0d load=1",
                 f, data595, scan_idx, word_load, e.word, e.idx);
      end
      if (f == 1) digit_en = 8'h00;
      f++;
    end
  endtask

  task automatic test_tearing();
    logic [15:0] ref_word;
    logic        tog;
    logic        ok_stable;
    logic        ok_load;
    do_reset(32'h0000_0301, 8'h00, 8'h05);
    ref_word = 16'hFFFF;
    tog      = 1'b0;
    for (int f = 0; f < 6; f++) begin
      ok_stable = 1'b1;
      ok_load   = 1'b1;
      for (int c = 1; c <= 32; c++) begin
        tick();
        if (c < 32) begin
          if (data595 !== ref_word) ok_stable = 1'b0;
          if (word_load !== 1'b0)   ok_load   = 1'b0;
        end else begin
          if (word_load !== 1'b1)   ok_load   = 1'b0;
          ref_word = data595;
        end
        tog       = ~tog;
        disp_data = tog ? 32'h0000_0ABC : 32'h0000_0301;
        digit_en  = tog ? 8'h0A : 8'h05;
        dp_en     = tog ? 8'hFF : 8'h00;
      end
      n_checks++;
      if (!ok_stable) begin
        n_fail++;
        $display("FAIL tearing_stable f%0d: data595 moved mid-frame, ok=%b expected 1", f, ok_stable);
      end
      n_checks++;
      if (!ok_load) begin
        n_fail++;
        $display("FAIL tearing_load f%0d: word_load not a 32-cycle pulse, ok=%b expected 1", f, ok_load);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic ok;
    do_reset(32'h0000_0005, 8'h00, 8'h01);
    push(16'hFFFF, 3'd0);
    push(16'h92FE, 3'd0);
    for (int f = 0; f < 2; f++) begin
      step_frame();
      e = sb.pop_front();
      n_checks++;
      if (data595 !== e.word || scan_idx !== e.idx) begin
        n_fail++;
        $display("FAIL midrst_pre f%0d: data595=%h idx=%0d expected %h idx=%0d",
                 f, data595, scan_idx, e.word, e.idx);
      end
    end
    repeat (17) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (data595 !== 16'hFFFF || word_load !== 1'b0 || scan_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_state: data595=%h load=%b idx=%0d expected FFFF load=0 idx=0",
               data595, word_load, scan_idx);
    end
    rst = 1'b0;
    ok  = 1'b1;
    repeat (31) begin
      tick();
      if (word_load !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_quiet: word_load before 32 cycles, ok=%b expected 1", ok);
    end
    tick();
    n_checks++;
    if (word_load !== 1'b1 || data595 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL midrst_first: load=%b data595=%h expected load=1 FFFF", word_load, data595);
    end
    push(16'h92FE, 3'd0);
    step_frame();
    e = sb.pop_front();
    n_checks++;
    if (data595 !== e.word || scan_idx !== e.idx || word_load !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_resume: data595=%h idx=%0d load=%b expected %h idx=%0d load=1",
               data595, scan_idx, word_load, e.word, e.idx);
    end
  endtask

  initial begin
    test_reset();
    test_idle_start();
    test_skip();
    test_snapshot();
    test_lamp();
    test_single_high_digit();
    test_tearing();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg595_scan.md
SEG595_SCAN -- requirements
Module: seg595_scan

Interface
REQ-001 Parameter HOLD_FRAMES, default 16: frames each digit is held; legal range 1..255.
REQ-002 Parameter SEG_ACT_LOW, default 1: 1 inverts the segment byte (common anode).
REQ-003 Parameter DIG_ACT_LOW, default 1: 1 inverts the digit-select byte.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 disp_data  in  32  eight hex nibbles; nibble k = bits [4k+3:4k] = digit k.
REQ-007 dp_en  in  8  decimal-point enable per digit.
REQ-008 digit_en  in  8  digit enable mask; 0 = digit skipped.
REQ-009 lamp_test  in  1  force all segments and all digits on.
REQ-010 data595  out  16  word to the 16-bit 595 shift driver; [15:8] segments {dp,g,f,e,d,c,b,a}, [7:0] one-hot digit select.
REQ-011 word_load  out  1  one-cycle pulse marking the first cycle a new data595 value is valid.
REQ-012 scan_idx  out  3  index of the digit currently displayed.

Function
REQ-013 frame_cnt (5 bit) SHALL count 0..31 freely, wrapping 31->0, in lockstep with the 32-cycle driver frame; both blocks are reset in the same cycle.
REQ-014 Boundary = rising edge at which frame_cnt==31; data595 SHALL change only at a boundary, never mid-frame.
REQ-015 word_load SHALL be 1 exactly in the cycle where frame_cnt==0, else 0.
REQ-016 Shadow registers (sh_data, sh_dp, sh_en) SHALL be the only source for encoding; inputs are sampled only at the capture points in REQ-019 and REQ-020.
REQ-017 Normal boundary (sh_en != 0): data595 <= encode(idx) using the pre-update idx, then hold_cnt increments.
REQ-018 When hold_cnt == HOLD_FRAMES-1 at a boundary: hold_cnt <= 0; idx <= first set bit of sh_en searching circularly from idx+1.
REQ-019 Wrap (search result <= idx, including a single enabled digit): capture inputs into shadows; idx <= lowest set bit of the incoming digit_en; if incoming digit_en == 0, enter idle with idx <= 0.
REQ-020 Idle boundary (sh_en == 0): data595 <= blank word; capture inputs; idx <= lowest set bit of the incoming digit_en, or 0 if none; hold_cnt <= 0.
REQ-021 encode(idx): seg = hex7(sh_data nibble idx) | (sh_dp[idx] << 7); sel = 8'b1 << idx; each byte is inverted per its ACT_LOW parameter.
REQ-022 hex7 table, active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 Blank word: all segments off and all digits off; with default parameters this is 16'hFFFF.
REQ-024 lamp_test sampled at a boundary SHALL load seg=all on and sel=all on, with default parameters 16'h0000; idx, hold_cnt and shadow updates continue unchanged.
REQ-025 scan_idx SHALL equal the idx encoded in the currently valid data595; it is updated at the same boundary.
REQ-026 Changes to inputs between capture points SHALL have no effect on data595.

Reset
REQ-027 While rst=1 at a clock edge: frame_cnt=0, hold_cnt=0, idx=0, scan_idx=0, shadows=0, data595=blank word (16'hFFFF with defaults), word_load=0.
REQ-028 Reset asserted mid-frame SHALL take effect at the next edge, discarding the partial frame; the first boundary after release occurs 32 edges later.

Verification (HOLD_FRAMES=2, other parameters default)
REQ-029 Idle start: reset, then digit_en=01, disp_data=0x00000005 -> frame 1 data595=FFFF; frames 2 onward 92FE (seg ~6D, sel ~01); scan_idx=0.
REQ-030 Skip: digit_en=05, disp_data=0x00000301 -> digit 0 (F9FE) for 2 frames, then digit 2 (B0FB) for 2 frames, then digit 0 again; digit 1 never selected.
REQ-031 Snapshot: change disp_data mid-pass -> data595 is unchanged until the wrap boundary; the new value appears from the next pass.
REQ-032 Tearing: toggle inputs every cycle -> data595 changes only at frame_cnt 31->0 edges, and word_load pulses every 32 cycles.
REQ-033 Lamp test: lamp_test=1 for 3 frames -> data595=0000 for those frames; scanning resumes at the correct idx and hold position afterwards.
REQ-034 Reset mid-frame: assert rst at frame_cnt=17 -> data595=FFFF at the next edge, word_load=0, and the first word_load occurs 32 cycles after release.
